// File: rtl/bram_sweep_tester_if.sv
// One BRAM port as seen by the sweep tester: write side, read side, registered read data.
interface bram_sweep_tester_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36
);
    logic                  WEN_o;
    logic [ADDR_WIDTH-1:0] WR_ADDR_o;
    logic [DATA_WIDTH-1:0] WDATA_o;
    logic                  REN_o;
    logic [ADDR_WIDTH-1:0] RD_ADDR_o;
    logic [DATA_WIDTH-1:0] RDATA_i;

    modport master (
        output WEN_o, WR_ADDR_o, WDATA_o, REN_o, RD_ADDR_o,
        input  RDATA_i
    );

    modport slave (
        input  WEN_o, WR_ADDR_o, WDATA_o, REN_o, RD_ADDR_o,
        output RDATA_i
    );
endinterface

// File: rtl/bram_sweep_tester.sv
// Write sweep then read sweep over an address window of one BRAM port, checking each
// returned word against an address-derived pattern and reporting pass/fail.
module bram_sweep_tester #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 36,
    parameter int BASE_ADDR  = 0,
    parameter int COUNT      = 512,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clock0,
    input  logic                  nreset_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_WIDTH-1:0]  err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    bram_sweep_tester_if.master   bram
);
    localparam int PW = (DATA_WIDTH > ADDR_WIDTH + 20) ? DATA_WIDTH : ADDR_WIDTH + 20;
    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0]         LAST = CW'(COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        logic [PW-1:0] t;
        t = PW'(a) | (PW'(a) << 20) | PW'(20'h55000);
        return t[DATA_WIDTH-1:0];
    endfunction

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         idx;
    logic                  wen, ren;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  exp_vld;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic                  mismatch;
    logic [ERR_WIDTH-1:0]  err_next;

    assign bram.WEN_o     = wen;
    assign bram.WR_ADDR_o = wr_addr;
    assign bram.WDATA_o   = wdata;
    assign bram.REN_o     = ren;
    assign bram.RD_ADDR_o = rd_addr;
    assign wr_addr_nxt    = wr_addr + ADDR_WIDTH'(1);

    // Case inequality so an X/Z return word is flagged rather than silently matching.
    always_comb begin
        mismatch = exp_vld && (bram.RDATA_i !== exp_data);
        err_next = err_cnt_o;
        if (mismatch && err_cnt_o != '1)
            err_next = err_cnt_o + ERR_WIDTH'(1);
    end

    always_ff @(posedge clock0 or negedge nreset_i) begin
        if (!nreset_i) begin
            state            <= IDLE;
            idx              <= '0;
            wen              <= 1'b0;
            ren              <= 1'b0;
            wr_addr          <= '0;
            rd_addr          <= '0;
            wdata            <= '0;
            exp_vld          <= 1'b0;
            exp_data         <= '0;
            exp_addr         <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
        end else begin
            // Expected word and address travel alongside the BRAM read latency.
            exp_vld  <= ren;
            exp_data <= pattern(rd_addr);
            exp_addr <= rd_addr;
            if (mismatch) begin
                err_cnt_o <= err_next;
                if (err_cnt_o == '0)
                    first_err_addr_o <= exp_addr;
            end

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state            <= WRITE;
                        busy_o           <= 1'b1;
                        done_o           <= 1'b0;
                        pass_o           <= 1'b0;
                        err_cnt_o        <= '0;
                        first_err_addr_o <= '0;
                        wen              <= 1'b1;
                        wr_addr          <= BASE;
                        wdata            <= pattern(BASE);
                        idx              <= '0;
                    end
                end
                WRITE: begin
                    if (idx == LAST) begin
                        state   <= READ;
                        wen     <= 1'b0;
                        ren     <= 1'b1;
                        rd_addr <= BASE;
                        idx     <= '0;
                    end else begin
                        idx     <= idx + CW'(1);
                        wr_addr <= wr_addr_nxt;
                        wdata   <= pattern(wr_addr_nxt);
                    end
                end
                READ: begin
                    if (idx == LAST) begin
                        state <= DRAIN;
                        ren   <= 1'b0;
                    end else begin
                        idx     <= idx + CW'(1);
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= (err_next == '0);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_sweep_tester.sv
// Bench for bram_sweep_tester: three configurations, each with a behavioural BRAM port,
// driven through a write/read scoreboard.
module tb_bram_sweep_tester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic [15:0] err_a, err_b, err_c;
    logic [9:0]  first_a, first_c;
    logic [11:0] first_b;

    bram_sweep_tester_if #(.ADDR_WIDTH(10), .DATA_WIDTH(36)) bus_a ();
    bram_sweep_tester_if #(.ADDR_WIDTH(12), .DATA_WIDTH(9))  bus_b ();
    bram_sweep_tester_if #(.ADDR_WIDTH(10), .DATA_WIDTH(36)) bus_c ();

    bram_sweep_tester #(.ADDR_WIDTH(10), .DATA_WIDTH(36), .BASE_ADDR(0), .COUNT(512), .ERR_WIDTH(16)) dut_a (
        .clock0(clk), .nreset_i(rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .err_cnt_o(err_a), .first_err_addr_o(first_a), .bram(bus_a));
    bram_sweep_tester #(.ADDR_WIDTH(12), .DATA_WIDTH(9), .BASE_ADDR(2048), .COUNT(2048), .ERR_WIDTH(16)) dut_b (
        .clock0(clk), .nreset_i(rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .err_cnt_o(err_b), .first_err_addr_o(first_b), .bram(bus_b));
    bram_sweep_tester #(.ADDR_WIDTH(10), .DATA_WIDTH(36), .BASE_ADDR('h3FE), .COUNT(4), .ERR_WIDTH(16)) dut_c (
        .clock0(clk), .nreset_i(rst_n), .start_i(start_c), .busy_o(busy_c), .done_o(done_c),
        .pass_o(pass_c), .err_cnt_o(err_c), .first_err_addr_o(first_c), .bram(bus_c));

    // Behavioural BRAM ports with one-cycle registered read; port A can corrupt bit 0 of one address.
    logic [35:0] mem_a [1024];
    logic [35:0] mem_c [1024];
    logic [8:0]  mem_b [4096];
    logic [35:0] q_a, q_c;
    logic [8:0]  q_b;
    int inj_addr = -1;

    always @(posedge clk) begin
        if (bus_a.WEN_o) mem_a[bus_a.WR_ADDR_o] <= bus_a.WDATA_o;
        if (bus_a.REN_o) q_a <= mem_a[bus_a.RD_ADDR_o] | ((int'(bus_a.RD_ADDR_o) == inj_addr) ? 36'd1 : 36'd0);
        if (bus_b.WEN_o) mem_b[bus_b.WR_ADDR_o] <= bus_b.WDATA_o;
        if (bus_b.REN_o) q_b <= mem_b[bus_b.RD_ADDR_o];
        if (bus_c.WEN_o) mem_c[bus_c.WR_ADDR_o] <= bus_c.WDATA_o;
        if (bus_c.REN_o) q_c <= mem_c[bus_c.RD_ADDR_o];
    end
    assign bus_a.RDATA_i = q_a;
    assign bus_b.RDATA_i = q_b;
    assign bus_c.RDATA_i = q_c;

    // Selected instance, zero-extended to the widest configuration.
    int sel = 0;
    logic        m_wen, m_ren, m_busy, m_done, m_pass;
    logic [11:0] m_wr_addr, m_rd_addr, m_first;
    logic [35:0] m_wdata;
    logic [15:0] m_err;
    always_comb begin
        m_wen = bus_a.WEN_o; m_ren = bus_a.REN_o; m_wr_addr = 12'(bus_a.WR_ADDR_o);
        m_rd_addr = 12'(bus_a.RD_ADDR_o); m_wdata = bus_a.WDATA_o; m_busy = busy_a;
        m_done = done_a; m_pass = pass_a; m_err = err_a; m_first = 12'(first_a);
        if (sel == 1) begin
            m_wen = bus_b.WEN_o; m_ren = bus_b.REN_o; m_wr_addr = bus_b.WR_ADDR_o;
            m_rd_addr = bus_b.RD_ADDR_o; m_wdata = 36'(bus_b.WDATA_o); m_busy = busy_b;
            m_done = done_b; m_pass = pass_b; m_err = err_b; m_first = first_b;
        end else if (sel == 2) begin
            m_wen = bus_c.WEN_o; m_ren = bus_c.REN_o; m_wr_addr = 12'(bus_c.WR_ADDR_o);
            m_rd_addr = 12'(bus_c.RD_ADDR_o); m_wdata = bus_c.WDATA_o; m_busy = busy_c;
            m_done = done_c; m_pass = pass_c; m_err = err_c; m_first = 12'(first_c);
        end
    end

    int base_t [3] = '{0, 2048, 'h3FE};
    int cnt_t  [3] = '{512, 2048, 4};
    int aw_t   [3] = '{10, 12, 10};
    int dw_t   [3] = '{36, 9, 36};

    typedef struct packed {
        logic [11:0] addr;
        logic [35:0] data;
    } wr_t;
    wr_t wq[$];
    int  rq[$];
    int  wr_log[$];
    int  rd_first;
    logic [35:0] seen5, seen1ff, seen805;
    int checks = 0;
    int errors = 0;

    function automatic logic [35:0] pat(input int a, input int dw);
        logic [63:0] t, mask;
        t    = 64'(a) | (64'(a) << 20) | 64'h55000;
        mask = (64'd1 << dw) - 64'd1;
        return 36'(t & mask);
    endfunction

    task automatic set_start(input int cfg, input logic v);
        if (cfg == 0) start_a = v;
        else if (cfg == 1) start_b = v;
        else start_c = v;
    endtask

    // n counts edges after the accepting edge; done is due at n = 2*COUNT+1,
    // i.e. cycle 2*COUNT+2 when the start cycle is cycle 0.
    task automatic run(input int cfg, input int restart_at, output int lat);
        int n;
        wr_t w;
        int ra;
        sel = cfg;
        wq.delete(); rq.delete(); wr_log.delete(); rd_first = -1;
        for (int i = 0; i < cnt_t[cfg]; i++) begin
            int a;
            a = (base_t[cfg] + i) % (1 << aw_t[cfg]);
            w.addr = 12'(a);
            w.data = pat(a, dw_t[cfg]);
            wq.push_back(w);
            rq.push_back(a);
        end
        @(negedge clk); set_start(cfg, 1'b1);
        @(negedge clk); set_start(cfg, 1'b0);
        checks++;
        if (m_busy !== 1'b1 || m_done !== 1'b0) begin
            errors++; $display("FAIL start_accept busy=%b done=%b want busy=1 done=0", m_busy, m_done);
        end
        n = 0; lat = -1;
        while (n < 2 * cnt_t[cfg] + 40) begin
            set_start(cfg, (n == restart_at) ? 1'b1 : 1'b0);
            checks++;
            if (m_wen === 1'b1 && m_ren === 1'b1) begin
                errors++; $display("FAIL wen_ren_exclusive n=%0d got both high want one", n);
            end
            if (m_wen === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++; $display("FAIL extra_write addr=%0h want no write", m_wr_addr);
                end else begin
                    w = wq.pop_front();
                    if (m_wr_addr !== w.addr || m_wdata !== w.data) begin
                        errors++;
                        $display("FAIL write got %0h:%0h want %0h:%0h", m_wr_addr, m_wdata, w.addr, w.data);
                    end
                    wr_log.push_back(int'(m_wr_addr));
                    if (cfg == 0 && m_wr_addr == 12'h005) seen5 = m_wdata;
                    if (cfg == 0 && m_wr_addr == 12'h1FF) seen1ff = m_wdata;
                    if (cfg == 1 && m_wr_addr == 12'h805) seen805 = m_wdata;
                end
            end
            if (m_ren === 1'b1) begin
                checks++;
                if (rd_first < 0) rd_first = int'(m_rd_addr);
                if (rq.size() == 0) begin
                    errors++; $display("FAIL extra_read addr=%0h want no read", m_rd_addr);
                end else begin
                    ra = rq.pop_front();
                    if (m_rd_addr !== 12'(ra)) begin
                        errors++; $display("FAIL read_addr got %0h want %0h", m_rd_addr, ra);
                    end
                end
            end
            if (m_done === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk); n++;
        end
        set_start(cfg, 1'b0);
        checks++;
        if (lat < 0) begin
            errors++; $display("FAIL done_timeout got none want n=%0d", 2 * cnt_t[cfg] + 1);
        end
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++; $display("FAIL leftover writes=%0d reads=%0d want 0 0", wq.size(), rq.size());
        end
    endtask

    task automatic check_result(input string name, input int lat, input int want_lat,
                                input logic want_pass, input int want_err, input int want_first);
        checks++;
        if (lat != want_lat) begin
            errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, want_lat);
        end
        checks++;
        if (m_pass !== want_pass || m_err !== 16'(want_err) || m_first !== 12'(want_first)) begin
            errors++;
            $display("FAIL %s_result got pass=%b err=%0d first=%0h want pass=%b err=%0d first=%0h",
                     name, m_pass, m_err, m_first, want_pass, want_err, want_first);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy_a, done_a, pass_a, err_a, first_a, bus_a.WEN_o, bus_a.REN_o, bus_a.WR_ADDR_o,
             bus_a.RD_ADDR_o, bus_a.WDATA_o} !== '0) begin
            errors++; $display("FAIL reset_a outputs not zero busy=%b done=%b wen=%b", busy_a, done_a, bus_a.WEN_o);
        end
        checks++;
        if ({busy_b, done_b, pass_b, err_b, first_b, bus_b.WEN_o, bus_b.REN_o, bus_c.WEN_o,
             busy_c, done_c, err_c} !== '0) begin
            errors++; $display("FAIL reset_bc outputs not zero busy_b=%b busy_c=%b", busy_b, busy_c);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        run(0, -1, lat);
        check_result("basic", lat, 1025, 1'b1, 0, 0);
        checks++;
        if (seen5 !== 36'h000555005) begin
            errors++; $display("FAIL wdata_5 got %0h want 000555005", seen5);
        end
        checks++;
        if (seen1ff !== 36'h01FF551FF) begin
            errors++; $display("FAIL wdata_1ff got %0h want 1FF551FF", seen1ff);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_wen !== 1'b0 || m_ren !== 1'b0) begin
            errors++; $display("FAIL done_hold got done=%b busy=%b want done=1 busy=0", m_done, m_busy);
        end
    endtask

    task automatic test_error_inject();
        int lat;
        inj_addr = 'h010;
        run(0, -1, lat);
        inj_addr = -1;
        check_result("inject", lat, 1025, 1'b0, 1, 'h010);
    endtask

    task automatic test_wide_base();
        int lat;
        run(1, -1, lat);
        check_result("wide", lat, 4097, 1'b1, 0, 0);
        checks++;
        if (seen805[8:0] !== 9'h005) begin
            errors++; $display("FAIL wdata_805 got %0h want 005", seen805);
        end
        checks++;
        if (wr_log.size() != 2048 || wr_log[0] != 'h800 || wr_log[wr_log.size()-1] != 'hFFF || rd_first != 'h800) begin
            errors++; $display("FAIL wide_range got first_wr=%0h rd_first=%0h want 800 800", wr_log[0], rd_first);
        end
    endtask

    task automatic test_wrap();
        int lat;
        int want [4] = '{'h3FE, 'h3FF, 'h000, 'h001};
        run(2, -1, lat);
        check_result("wrap", lat, 9, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log.size() <= i || wr_log[i] != want[i]) begin
                errors++; $display("FAIL wrap_addr_%0d got %0h want %0h", i, (wr_log.size() > i) ? wr_log[i] : -1, want[i]);
            end
        end
        checks++;
        if (rd_first != 'h3FE) begin
            errors++; $display("FAIL wrap_rd_first got %0h want 3fe", rd_first);
        end
    endtask

    task automatic test_restart_ignored();
        int lat;
        run(0, 100, lat);
        check_result("restart", lat, 1025, 1'b1, 0, 0);
    endtask

    task automatic test_reset_mid();
        int lat;
        sel = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_wen !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid got wen=%b busy=%b done=%b err=%0d want 0 0 0 0", m_wen, m_busy, m_done, m_err);
        end
        @(negedge clk); rst_n = 1'b1;
        run(0, -1, lat);
        check_result("after_reset", lat, 1025, 1'b1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error_inject();
        test_wide_base();
        test_wrap();
        test_restart_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_sweep_tester.md
Name: bram_sweep_tester

Overview:
- Self-checking traffic generator that sits directly upstream of one port of the qlf_k6n10f dual-port BRAM wrappers (dpram_36x1024, dpram_18x2048, dpram_9x4096).
- Drives a write sweep over an address window, then a read sweep over the same window, and compares returned data against a deterministic address-derived pattern.
- One instance per BRAM port; it lets hardware runs and post-synthesis simulation report pass/fail without a behavioural bench.

Parameters:
- ADDR_WIDTH, 10, width of the BRAM address bus.
- DATA_WIDTH, 36, width of the BRAM data bus.
- BASE_ADDR, 0, first address of the sweep window.
- COUNT, 512, number of addresses swept. Must be at least 1 and at most 2^ADDR_WIDTH.
- ERR_WIDTH, 16, width of the error counter.

Ports:
- clock0  in  1  sole clock; every register is rising-edge.
- nreset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request to begin a test run.
- busy_o  out  1  high while a run is in progress.
- done_o  out  1  high once a run completes; held until the next accepted start.
- pass_o  out  1  valid when done_o is high; 1 means zero mismatches.
- err_cnt_o  out  ERR_WIDTH  mismatch count; saturates at all-ones.
- first_err_addr_o  out  ADDR_WIDTH  address of the first mismatch; 0 if there was none.
- WEN_o  out  1  BRAM write enable.
- WR_ADDR_o  out  ADDR_WIDTH  BRAM write address.
- WDATA_o  out  DATA_WIDTH  BRAM write data.
- REN_o  out  1  BRAM read enable.
- RD_ADDR_o  out  ADDR_WIDTH  BRAM read address.
- RDATA_i  in  DATA_WIDTH  BRAM read data, valid one cycle after REN_o.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE.
- Pattern: P(a) = (a | (a<<20) | 0x55000), truncated to DATA_WIDTH. Here a is the full ADDR_WIDTH address, zero-extended before shifting.
- Address sequence: BASE_ADDR, BASE_ADDR+1, and so on, modulo 2^ADDR_WIDTH (wraps past all-ones to 0).
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start_i=1 → WRITE.
  - On this transition clear err_cnt_o, first_err_addr_o, pass_o and done_o, and set busy_o=1.
- WRITE:
  - Each cycle present WEN_o=1, WR_ADDR_o=a, WDATA_o=P(a), for exactly COUNT consecutive cycles.
  - After the last write → READ. WEN_o=0 from the first READ cycle.
- READ:
  - Each cycle present REN_o=1 and RD_ADDR_o=a, for COUNT consecutive cycles with no gaps.
  - An expected-value/address pipeline register delays P(a) and a by one cycle.
  - On the cycle after each REN_o=1, compare RDATA_i with the delayed P(a).
  - Compare with case equality: X or Z on RDATA_i counts as a mismatch.
- DRAIN:
  - One cycle with REN_o=0; performs the final comparison, then → DONE.
- Mismatch handling:
  - err_cnt_o increments, saturating.
  - If this is the first mismatch of the run, first_err_addr_o captures the delayed address.
- DONE:
  - busy_o=0, done_o=1, pass_o=(err_cnt_o==0), with the final error included.
  - start_i=1 → WRITE, following the same clearing rules as from IDLE.
- Total run latency: start accepted at cycle 0; done_o first high at cycle 2*COUNT+2.
- start_i while busy_o=1 is ignored; no restart and no effect on counters.
- WEN_o and REN_o are never high in the same cycle.
- Reset mid-run:
  - All outputs return to 0 asynchronously; WEN_o drops immediately.
  - BRAM contents are not this block's concern.
- COUNT=2^ADDR_WIDTH with BASE_ADDR≠0 wraps and covers every address exactly once.

Test Plan:
- Single-cycle start, ADDR_WIDTH=10, DATA_WIDTH=36, BASE_ADDR=0, COUNT=512, with dpram_36x1024 attached:
  - WDATA_o at address 5 is 0x000555005; at address 0x1FF it is 0x1FF551FF.
  - done_o rises at cycle 1026 with pass_o=1 and err_cnt_o=0.
- Same configuration, with the bench forcing bit 0 of RDATA_i high during the read return for address 0x010 only:
  - err_cnt_o=1, first_err_addr_o=0x010, pass_o=0.
- DATA_WIDTH=9, ADDR_WIDTH=12, BASE_ADDR=2048, COUNT=2048, with dpram_9x4096:
  - WDATA_o at 0x805 is 0x005.
  - Addresses run from 0x800 to 0xFFF, then the read phase starts at 0x800; pass_o=1.
- BASE_ADDR=0x3FE, COUNT=4, ADDR_WIDTH=10:
  - Write addresses are 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
  - Read addresses follow the same order; pass_o=1.
- Assert start_i again at cycle 100 of a run:
  - No effect on the run; done_o still rises at cycle 2*COUNT+2.
- Drive nreset_i low during the WRITE phase:
  - WEN_o, busy_o, done_o and err_cnt_o are 0 immediately.
  - A subsequent start runs a full, passing test.
